threshold_channel_trigger: RTL and testbench

Per-channel threshold discriminator. One instance per ADC channel B0..B7. It qualifies incoming samples against a programmable threshold and produces the time stamp/decision pair consumed by the global threshold coordinator. It owns the per-channel 16-bit sample time stamp, which wraps at 16'hFFFF; the coordinator relies on that wrap to count iterations.

---
 rtl/threshold_channel_trigger.sv | 126 ++++++++++++
 tb/tb_threshold_channel_trigger.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/threshold_channel_trigger.sv
// threshold_channel_trigger: per-channel threshold discriminator producing a wrapping time stamp and a trigger decision.
// Optional EMA baseline subtraction is built when THRESHOLD_BASELINE_SUBTRACT_EN is defined.
module threshold_channel_trigger #(
    parameter int DATA_W          = 14,
    parameter int MIN_ABOVE       = 3,
    parameter int HOLDOFF_SAMPLES = 16,
    parameter int BASELINE_SHIFT  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] threshold,
    input  logic [DATA_W-1:0] release_threshold,
    output logic [15:0]       time_stamp,
    output logic              decision,
    output logic              busy
);
    localparam logic [1:0]  IDLE      = 2'd0;
    localparam logic [1:0]  ARMING    = 2'd1;
    localparam logic [1:0]  TRIGGERED = 2'd2;
    localparam logic [1:0]  HOLDOFF   = 2'd3;
    localparam logic [3:0]  RUN_MAX   = 4'(MIN_ABOVE);
    localparam logic [15:0] HOLD_INIT = 16'(HOLDOFF_SAMPLES);

    if (MIN_ABOVE < 1 || MIN_ABOVE > 15 || HOLDOFF_SAMPLES < 0 || HOLDOFF_SAMPLES > 65535 || BASELINE_SHIFT < 0) begin : g_bad_cfg
        $error("threshold_channel_trigger: parameter out of range");
    end

    logic [1:0]        state, state_nx;
    logic [3:0]        run, run_nx;
    logic [15:0]       hold, hold_nx;
    logic              ts_started;
    logic [DATA_W-1:0] level, rel_level;
    logic              above, below_rel;

`ifdef THRESHOLD_BASELINE_SUBTRACT_EN
    localparam int ACC_W = DATA_W + BASELINE_SHIFT;
    logic [ACC_W-1:0]  acc;
    logic              base_init;
    logic [DATA_W-1:0] base;
    // acc holds the baseline in fixed point, so base += (sample - base) >>> SHIFT keeps its fraction
    assign base  = base_init ? acc[ACC_W-1:BASELINE_SHIFT] : sample_data;
    assign level = (sample_data > base) ? sample_data - base : '0;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            base_init <= 1'b0;
        end else if (sample_valid && !base_init) begin
            acc       <= {sample_data, {BASELINE_SHIFT{1'b0}}};
            base_init <= 1'b1;
        end else if (sample_valid && state == IDLE) begin
            acc <= acc + ACC_W'(sample_data) - ACC_W'(base);
        end
    end
`else
    assign level = sample_data;
`endif

    assign rel_level = (release_threshold < threshold) ? release_threshold : threshold;
    assign above     = level >= threshold;
    assign below_rel = level < rel_level;

    always_comb begin
        state_nx = state;
        run_nx   = run;
        hold_nx  = hold;
        case (state)
            IDLE: begin
                if (above) begin
                    run_nx   = 4'd1;
                    state_nx = (MIN_ABOVE == 1) ? TRIGGERED : ARMING;
                end
            end
            ARMING: begin
                if (above) begin
                    run_nx   = (run >= RUN_MAX) ? RUN_MAX : run + 4'd1;
                    state_nx = (run_nx == RUN_MAX) ? TRIGGERED : ARMING;
                end else begin
                    run_nx   = 4'd0;
                    state_nx = IDLE;
                end
            end
            TRIGGERED: begin
                if (below_rel) begin
                    run_nx   = 4'd0;
                    hold_nx  = HOLD_INIT;
                    state_nx = (HOLDOFF_SAMPLES == 0) ? IDLE : HOLDOFF;
                end
            end
            default: begin
                run_nx   = 4'd0;
                hold_nx  = hold - 16'd1;
                state_nx = (hold_nx == 16'd0) ? IDLE : HOLDOFF;
            end
        endcase
    end

    // the first valid sample after reset reads index 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            time_stamp <= 16'd0;
            ts_started <= 1'b0;
        end else if (sample_valid) begin
            time_stamp <= ts_started ? time_stamp + 16'd1 : 16'd0;
            ts_started <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            state    <= IDLE;
            run      <= 4'd0;
            hold     <= 16'd0;
            decision <= 1'b0;
            busy     <= 1'b0;
        end else if (sample_valid) begin
            state    <= state_nx;
            run      <= run_nx;
            hold     <= hold_nx;
            decision <= state_nx == TRIGGERED;
            busy     <= state_nx != IDLE;
        end
    end
endmodule

// File: tb/tb_threshold_channel_trigger.sv
// tb_threshold_channel_trigger: directed vector bench for threshold_channel_trigger.
// A second instance covers MIN_ABOVE=1 / HOLDOFF_SAMPLES=0.
module tb_threshold_channel_trigger;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        sample_valid = 1'b0;
    logic [13:0] sample_data = '0;
    logic [13:0] threshold = 14'd1000;
    logic [13:0] release_threshold = 14'd800;
    logic [15:0] time_stamp, time_stamp2;
    logic        decision, decision2, busy, busy2;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        en;
        logic        v;
        logic [13:0] d;
        logic [15:0] ts;
        logic        dec;
        logic        busy;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    threshold_channel_trigger #(.DATA_W(14), .MIN_ABOVE(3), .HOLDOFF_SAMPLES(4), .BASELINE_SHIFT(6)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid), .sample_data(sample_data),
        .threshold(threshold), .release_threshold(release_threshold),
        .time_stamp(time_stamp), .decision(decision), .busy(busy)
    );

    threshold_channel_trigger #(.DATA_W(14), .MIN_ABOVE(1), .HOLDOFF_SAMPLES(0), .BASELINE_SHIFT(6)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid), .sample_data(sample_data),
        .threshold(threshold), .release_threshold(release_threshold),
        .time_stamp(time_stamp2), .decision(decision2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic v, input logic [13:0] d);
        enable = en;
        sample_valid = v;
        sample_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic v, input logic [13:0] d, input logic [15:0] ts, input logic dec, input logic b);
        vec_t x;
        x.en = en; x.v = v; x.d = d; x.ts = ts; x.dec = dec; x.busy = b;
        vecs.push_back(x);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 14'd0);
        drive(1'b1, 1'b0, 14'd0);
        chk("reset_ts", 32'(time_stamp), 32'd0);
        chk("reset_dec", 32'(decision), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
`ifdef THRESHOLD_BASELINE_SUBTRACT_EN
        for (int i = 0; i < 200; i++) drive(1'b1, 1'b1, 14'd500);
        chk("bl_idle_dec", 32'(decision), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 14'd1400);
            chk("bl_1400_dec", 32'(decision), 32'd0);
        end
        drive(1'b1, 1'b1, 14'd1600);
        chk("bl_1600a", 32'(decision), 32'd0);
        drive(1'b1, 1'b1, 14'd1600);
        chk("bl_1600b", 32'(decision), 32'd0);
        drive(1'b1, 1'b1, 14'd1600);
        chk("bl_1600c", 32'(decision), 32'd1);
        chk("bl_ts", 32'(time_stamp), 32'd205);
`else
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 14'd0);
            chk("pre_ts", 32'(time_stamp), 32'(i));
            chk("pre_dec", 32'(decision), 32'd0);
        end
        add(1, 1, 0,    10, 0, 0);
        add(1, 1, 1000, 11, 0, 1);
        add(1, 1, 1001, 12, 0, 1);
        add(1, 1, 1002, 13, 1, 1);
        add(1, 1, 900,  14, 1, 1);
        add(1, 1, 850,  15, 1, 1);
        add(1, 1, 799,  16, 0, 1);
        add(1, 1, 1200, 17, 0, 1);
        add(1, 1, 1200, 18, 0, 1);
        add(1, 1, 1200, 19, 0, 1);
        add(1, 1, 1200, 20, 0, 0);
        add(1, 1, 1200, 21, 0, 1);
        add(1, 1, 1200, 22, 0, 1);
        add(1, 1, 1200, 23, 1, 1);
        add(1, 0, 0,    23, 1, 1);
        add(1, 1, 0,    24, 0, 1);
        add(1, 1, 0,    25, 0, 1);
        add(1, 1, 0,    26, 0, 1);
        add(1, 1, 0,    27, 0, 1);
        add(1, 1, 0,    28, 0, 0);
        add(1, 1, 1000, 29, 0, 1);
        add(1, 1, 1000, 30, 0, 1);
        add(1, 1, 999,  31, 0, 0);
        add(1, 1, 1000, 32, 0, 1);
        add(1, 1, 1000, 33, 0, 1);
        add(1, 1, 1000, 34, 1, 1);
        add(0, 1, 1000, 35, 0, 0);
        add(0, 0, 0,    35, 0, 0);
        add(1, 1, 1000, 36, 0, 1);
        add(1, 1, 1000, 37, 0, 1);
        add(1, 1, 1000, 38, 1, 1);
        foreach (vecs[k]) begin
            drive(vecs[k].en, vecs[k].v, vecs[k].d);
            chk($sformatf("vec%0d_ts", k), 32'(time_stamp), 32'(vecs[k].ts));
            chk($sformatf("vec%0d_dec", k), 32'(decision), 32'(vecs[k].dec));
            chk($sformatf("vec%0d_busy", k), 32'(busy), 32'(vecs[k].busy));
        end
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 14'd0);
        chk("midtrig_rst_ts", 32'(time_stamp), 32'd0);
        chk("midtrig_rst_dec", 32'(decision), 32'd0);
        chk("midtrig_rst_busy", 32'(busy), 32'd0);
        chk("midtrig_rst_dec2", 32'(decision2), 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 14'd1000);
        chk("first_ts", 32'(time_stamp), 32'd0);
        chk("min1_fire", 32'(decision2), 32'd1);
        chk("min3_arm", 32'(decision), 32'd0);
        drive(1'b1, 1'b1, 14'd1100);
        release_threshold = 14'd1200;
        drive(1'b1, 1'b1, 14'd1100);
        chk("rel_min_hold2", 32'(decision2), 32'd1);
        chk("rel_min_fire", 32'(decision), 32'd1);
        drive(1'b1, 1'b1, 14'd999);
        chk("rel_min_drop2", 32'(decision2), 32'd0);
        chk("hold0_idle2", 32'(busy2), 32'd0);
        chk("rel_min_drop", 32'(decision), 32'd0);
        chk("holdoff_busy", 32'(busy), 32'd1);
        drive(1'b1, 1'b1, 14'd1000);
        chk("hold0_refire2", 32'(decision2), 32'd1);
        release_threshold = 14'd800;
        do_reset();
        begin
            logic seen_dec;
            seen_dec = 1'b0;
            for (int i = 0; i < 70000; i++) begin
                drive(1'b1, 1'b1, 14'd0);
                seen_dec |= decision;
                if (i == 65535) chk("wrap_ffff", 32'(time_stamp), 32'h0000_FFFF);
                if (i == 65536) chk("wrap_0000", 32'(time_stamp), 32'd0);
            end
            chk("wrap_end", 32'(time_stamp), 32'h116F);
            chk("wrap_no_dec", 32'(seen_dec), 32'd0);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
